// File: rtl/elevator_scheduler.sv
// SCAN-policy elevator sequencer: latches floor calls, steps the car one floor per
// travel interval, and runs a timed door cycle at each requested floor.
module elevator_scheduler #(
    parameter int FLOORS       = 3,
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] button,
    output logic [FLOORS-1:0] led,
    output logic [FLOORS-1:0] floor,
    output logic              door,
    output logic              moving,
    output logic              dir_up
);

    localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN} state_t;

    state_t          state;
    logic [TW-1:0]   travel_cnt;
    logic [DW-1:0]   door_cnt;

    logic [FLOORS-1:0] req;
    logic [FLOORS-1:0] below_mask;
    logic [FLOORS-1:0] above_mask;
    logic [FLOORS-1:0] floor_next;
    logic              above;
    logic              below;
    logic              at_req;
    logic              arrive_req;
    logic              hold;
    logic              ahead;

    // floor is one-hot, so floor-1 marks every floor strictly below the car.
    always_comb begin
        req        = led | button;
        below_mask = floor - FLOORS'(1);
        above_mask = ~(below_mask | floor);
        above      = |(req & above_mask);
        below      = |(req & below_mask);
        at_req     = |(req & floor);
        floor_next = dir_up ? (floor << 1) : (floor >> 1);
        arrive_req = |(req & floor_next);
        hold       = |(button & floor);
        ahead      = dir_up ? above : below;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            led        <= '0;
            floor      <= FLOORS'(1);
            door       <= 1'b0;
            moving     <= 1'b0;
            dir_up     <= 1'b1;
            travel_cnt <= '0;
            door_cnt   <= '0;
        end else begin
            led <= led | button;
            case (state)
                IDLE: begin
                    if (at_req) begin
                        state    <= DOOR_OPEN;
                        door     <= 1'b1;
                        door_cnt <= '0;
                        led      <= (led | button) & ~floor;
                    end else if (ahead) begin
                        state      <= MOVE;
                        moving     <= 1'b1;
                        travel_cnt <= '0;
                    end else if (dir_up ? below : above) begin
                        state      <= MOVE;
                        moving     <= 1'b1;
                        travel_cnt <= '0;
                        dir_up     <= ~dir_up;
                    end
                end
                MOVE: begin
                    // Nothing left in the travel direction (end floor): stop rather than step off the shaft.
                    if (!ahead) begin
                        state      <= IDLE;
                        moving     <= 1'b0;
                        travel_cnt <= '0;
                    end else if (travel_cnt != TRAVEL_LAST) begin
                        travel_cnt <= travel_cnt + TW'(1);
                    end else begin
                        floor      <= floor_next;
                        travel_cnt <= '0;
                        if (arrive_req) begin
                            state    <= DOOR_OPEN;
                            moving   <= 1'b0;
                            door     <= 1'b1;
                            door_cnt <= '0;
                            led      <= (led | button) & ~floor_next;
                        end
                    end
                end
                DOOR_OPEN: begin
                    // A call for the floor the door is already open at is a hold, never a pending request.
                    led <= (led | button) & ~floor;
                    if (hold) begin
                        door_cnt <= '0;
                    end else if (door_cnt != DOOR_LAST) begin
                        door_cnt <= door_cnt + DW'(1);
                    end else begin
                        state <= IDLE;
                        door  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    door   <= 1'b0;
                    moving <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: default 3-floor car plus a 5-floor,
// single-tick-travel instance sharing clock and reset.
module tb_elevator_scheduler;

    logic       clk;
    logic       reset;
    logic [2:0] button;
    logic [2:0] led;
    logic [2:0] floor;
    logic       door;
    logic       moving;
    logic       dir_up;

    logic [4:0] button5;
    logic [4:0] led5;
    logic [4:0] floor5;
    logic       door5;
    logic       moving5;
    logic       dir_up5;

    int total;
    int bad;

    elevator_scheduler dut (
        .clk    (clk),
        .reset  (reset),
        .button (button),
        .led    (led),
        .floor  (floor),
        .door   (door),
        .moving (moving),
        .dir_up (dir_up)
    );

    elevator_scheduler #(
        .FLOORS       (5),
        .TRAVEL_TICKS (1),
        .DOOR_TICKS   (3)
    ) dut5 (
        .clk    (clk),
        .reset  (reset),
        .button (button5),
        .led    (led5),
        .floor  (floor5),
        .door   (door5),
        .moving (moving5),
        .dir_up (dir_up5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        button  = '0;
        button5 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (led !== 3'b000) begin bad++; $display("FAIL reset_led: got %b want 000", led); end
        total++; if (floor !== 3'b001) begin bad++; $display("FAIL reset_floor: got %b want 001", floor); end
        total++; if (door !== 1'b0) begin bad++; $display("FAIL reset_door: got %b want 0", door); end
        total++; if (moving !== 1'b0) begin bad++; $display("FAIL reset_moving: got %b want 0", moving); end
        total++; if (dir_up !== 1'b1) begin bad++; $display("FAIL reset_dir_up: got %b want 1", dir_up); end
        total++; if (floor5 !== 5'b00001) begin bad++; $display("FAIL reset_floor5: got %b want 00001", floor5); end
    endtask

    // Call to the top floor from floor 0, checked edge by edge through the door cycle.
    task automatic test_travel_up();
        logic [2:0] exp_f [8];
        logic [2:0] exp_l [8];
        logic       exp_m [8];
        logic       exp_d [8];
        exp_f = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
        exp_l = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        exp_m = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        button = 3'b100;
        for (int e = 0; e < 8; e++) begin
            step();
            button = 3'b000;
            total++; if (floor !== exp_f[e]) begin bad++; $display("FAIL up_floor e%0d: got %b want %b", e + 1, floor, exp_f[e]); end
            total++; if (led !== exp_l[e]) begin bad++; $display("FAIL up_led e%0d: got %b want %b", e + 1, led, exp_l[e]); end
            total++; if (moving !== exp_m[e]) begin bad++; $display("FAIL up_moving e%0d: got %b want %b", e + 1, moving, exp_m[e]); end
            total++; if (door !== exp_d[e]) begin bad++; $display("FAIL up_door e%0d: got %b want %b", e + 1, door, exp_d[e]); end
            total++; if (dir_up !== 1'b1) begin bad++; $display("FAIL up_dir e%0d: got %b want 1", e + 1, dir_up); end
        end
    endtask

    task automatic test_same_floor();
        do_reset();
        button = 3'b001;
        step();
        button = 3'b000;
        total++; if (door !== 1'b1) begin bad++; $display("FAIL same_door_open: got %b want 1", door); end
        for (int e = 1; e <= 4; e++) begin
            total++; if (led !== 3'b000) begin bad++; $display("FAIL same_led e%0d: got %b want 000", e, led); end
            total++; if (floor !== 3'b001 || moving !== 1'b0) begin bad++; $display("FAIL same_still e%0d: got floor=%b moving=%b want 001/0", e, floor, moving); end
            step();
        end
        total++; if (door !== 1'b0) begin bad++; $display("FAIL same_door_close: got %b want 0", door); end
    endtask

    // Floor 0 is called just after the car leaves floor 1 upward: floor 2 first, then reverse.
    task automatic test_scan_reverse();
        do_reset();
        button = 3'b100;
        step();
        button = 3'b000;
        step();
        step();
        total++; if (floor !== 3'b010 || dir_up !== 1'b1) begin bad++; $display("FAIL rev_at1: got floor=%b dir=%b want 010/1", floor, dir_up); end
        button = 3'b001;
        step();
        button = 3'b000;
        total++; if (led !== 3'b101) begin bad++; $display("FAIL rev_latched: got %b want 101", led); end
        step();
        total++; if (floor !== 3'b100 || door !== 1'b1 || led !== 3'b001) begin bad++; $display("FAIL rev_serve2: got floor=%b door=%b led=%b want 100/1/001", floor, door, led); end
        repeat (3) step();
        total++; if (door !== 1'b0 || moving !== 1'b0) begin bad++; $display("FAIL rev_idle: got door=%b moving=%b want 0/0", door, moving); end
        step();
        total++; if (moving !== 1'b1 || dir_up !== 1'b0) begin bad++; $display("FAIL rev_depart: got moving=%b dir=%b want 1/0", moving, dir_up); end
        repeat (2) step();
        total++; if (floor !== 3'b010 || moving !== 1'b1) begin bad++; $display("FAIL rev_pass1: got floor=%b moving=%b want 010/1", floor, moving); end
        repeat (2) step();
        total++; if (floor !== 3'b001 || door !== 1'b1 || moving !== 1'b0) begin bad++; $display("FAIL rev_arrive0: got floor=%b door=%b moving=%b want 001/1/0", floor, door, moving); end
        total++; if (led !== 3'b000) begin bad++; $display("FAIL rev_led_end: got %b want 000", led); end
    endtask

    task automatic test_door_hold();
        do_reset();
        button = 3'b100;
        step();
        button = 3'b000;
        repeat (4) step();
        total++; if (door !== 1'b1 || floor !== 3'b100) begin bad++; $display("FAIL hold_open: got door=%b floor=%b want 1/100", door, floor); end
        button = 3'b100;
        for (int e = 0; e < 4; e++) begin
            step();
            total++; if (door !== 1'b1 || led !== 3'b000) begin bad++; $display("FAIL hold_press e%0d: got door=%b led=%b want 1/000", e, door, led); end
        end
        button = 3'b000;
        for (int e = 0; e < 2; e++) begin
            step();
            total++; if (door !== 1'b1 || led !== 3'b000) begin bad++; $display("FAIL hold_tail e%0d: got door=%b led=%b want 1/000", e, door, led); end
        end
        step();
        total++; if (door !== 1'b0 || led !== 3'b000) begin bad++; $display("FAIL hold_close: got door=%b led=%b want 0/000", door, led); end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        button = 3'b100;
        step();
        button = 3'b001;
        step();
        button = 3'b000;
        step();
        total++; if (floor !== 3'b010 || moving !== 1'b1 || led !== 3'b101) begin bad++; $display("FAIL rmm_pre: got floor=%b moving=%b led=%b want 010/1/101", floor, moving, led); end
        #1;
        reset = 1'b1;
        #1;
        total++; if (floor !== 3'b001 || led !== 3'b000 || moving !== 1'b0) begin bad++; $display("FAIL rmm_async: got floor=%b led=%b moving=%b want 001/000/0", floor, led, moving); end
        total++; if (door !== 1'b0 || dir_up !== 1'b1) begin bad++; $display("FAIL rmm_async2: got door=%b dir=%b want 0/1", door, dir_up); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Five floors, one tick per floor: calls at 2 and 4 from floor 0.
    task automatic test_five_floors();
        logic [4:0] exp_f [12];
        logic       exp_m [12];
        logic       exp_d [12];
        exp_f = '{5'b00001, 5'b00010, 5'b00100, 5'b00100, 5'b00100, 5'b00100,
                  5'b00100, 5'b01000, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
        exp_m = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_d = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        button5 = 5'b10100;
        for (int e = 0; e < 12; e++) begin
            step();
            button5 = 5'b00000;
            total++; if (floor5 !== exp_f[e]) begin bad++; $display("FAIL f5_floor e%0d: got %b want %b", e + 1, floor5, exp_f[e]); end
            total++; if (moving5 !== exp_m[e]) begin bad++; $display("FAIL f5_moving e%0d: got %b want %b", e + 1, moving5, exp_m[e]); end
            total++; if (door5 !== exp_d[e]) begin bad++; $display("FAIL f5_door e%0d: got %b want %b", e + 1, door5, exp_d[e]); end
            total++; if ((door5 & moving5) !== 1'b0) begin bad++; $display("FAIL f5_exclusive e%0d: got door=%b moving=%b want not both", e + 1, door5, moving5); end
        end
        total++; if (led5 !== 5'b00000) begin bad++; $display("FAIL f5_led_end: got %b want 00000", led5); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        button  = '0;
        button5 = '0;
        test_reset();
        test_travel_up();
        test_same_floor();
        test_scan_reverse();
        test_door_hold();
        test_reset_mid_move();
        test_five_floors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

SCAN-policy request scheduler and car sequencer for the elevator controller. It latches floor-call buttons and decides the travel direction. It steps the car one floor per travel interval, opens the door at requested floors and times it closed. It replaces the fixed three-floor movement logic with a parameterised controller, driven from the slow `clk` produced by the frequency divider.

## Interface
- `FLOORS`, default 3: number of floors; floor 0 is the bottom.
- `TRAVEL_TICKS`, default 2: `clk` cycles per one-floor move, ≥1.
- `DOOR_TICKS`, default 3: `clk` cycles the door stays open, ≥1.

- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `button`, input, FLOORS: level call request, one bit per floor.
- `led`, output, FLOORS: pending (latched, unserved) requests.
- `floor`, output, FLOORS: one-hot current car position.
- `door`, output, 1: door open.
- `moving`, output, 1: car travelling.
- `dir_up`, output, 1: current or last travel direction, 1 = up.

## Operation
- Reset values: `led`=0, `floor`=one-hot bit 0, `door`=0, `moving`=0, `dir_up`=1, state IDLE, both counters 0.
- Effective request vector `req = led | button`. All decisions use `req`, so a press is acted on in the same edge it is sampled.
- Latching: each edge sets `led[i] <= led[i] | button[i]`. Exceptions:
  - The bit of a floor being served (entering DOOR_OPEN) is cleared.
  - A press of the current floor during DOOR_OPEN is never latched.
- `above` / `below`: OR of `req` bits strictly above / below the current floor.
- States:
  - IDLE (`door`=0, `moving`=0):
    - If `req[cur]`: go to DOOR_OPEN and clear `led[cur]`.
    - Else, if `dir_up` is set: `above` → MOVE up; else `below` → MOVE down with `dir_up`=0.
    - Else, if `dir_up` is clear: `below` → MOVE down; else `above` → MOVE up with `dir_up`=1.
    - Else: stay in IDLE.
    - On entry to MOVE, the travel counter is 0.
  - MOVE (`moving`=1):
    - While the travel counter is below TRAVEL_TICKS-1, increment it.
    - When it equals TRAVEL_TICKS-1: shift `floor` one position in `dir_up` direction and reset the counter.
    - If `req[new floor]`: go to DOOR_OPEN (`moving`=0, `door`=1, clear `led[new]`).
    - Else: remain in MOVE.
    - Guard: a step is never taken past floor 0 or FLOORS-1. At an end floor with no `req` in the travel direction, go to IDLE.
  - DOOR_OPEN (`door`=1):
    - The door counter is 0 on entry.
    - `button[cur]` restarts the counter to 0 (door hold).
    - Else, if the counter is below DOOR_TICKS-1, increment it.
    - Else go to IDLE (`door`=0).
- Requests at other floors are latched in any state and served by SCAN: finish the current direction, then reverse.
- `door` and `moving` are never 1 simultaneously.
- `floor` is always exactly one-hot.

## Timing
- All outputs are registered.
- IDLE → MOVE or DOOR_OPEN takes 1 edge after `req` becomes visible.
- Floor-to-floor time is exactly TRAVEL_TICKS cycles. Arrival and door opening happen on the same edge.
- `door` is high for exactly DOOR_TICKS cycles absent a hold. Each hold press extends it to DOOR_TICKS cycles after the last press edge.
- After the door closes, at least 1 IDLE cycle precedes the next MOVE.
- A press of the current floor while in MOVE (car just departed) is latched and served on a later pass.
- Multiple simultaneous presses are all latched.
- `reset` asserted mid-MOVE or mid-DOOR_OPEN forces all reset values immediately, independent of `clk`. Pending requests are lost.

## Test plan
- Reset, then pulse `button`=100 for 1 cycle (defaults).
  - `moving`=1 on edge 1.
  - `floor`=010 on edge 3.
  - `floor`=100, `door`=1, `led`=000 on edge 5.
  - `door`=0 on edge 8.
- At floor 0, press `button`=001.
  - `door`=1 next edge.
  - `led` bit 0 stays 0.
  - No movement.
- Car at floor 1 going up with requests 100 and 001 latched.
  - Serves floor 2 first.
  - After IDLE, `dir_up`=0, reaches floor 0 in 2×TRAVEL_TICKS cycles.
  - `led`=000 at end.
- Door open at floor 2; hold `button[2]` for 4 cycles, then release.
  - `door` stays 1 throughout the hold, plus 3 cycles after the last press edge.
  - `led[2]` is never set.
- Mid-MOVE (floor 1 → 2), assert `reset`.
  - Outputs go to `floor`=001, `led`=0, `moving`=0 before the next `clk` edge.
- FLOORS=5, TRAVEL_TICKS=1; press floors 4 and 2 together from floor 0.
  - Stops at 2, door cycle, continues to 4.
  - `door` and `moving` are never both 1.
